// File: rtl/ifu_prefetch.sv
// Instruction fetch unit: prefetches 32-bit method-area words into a byte buffer
// and presents the head as MBR (opcode) and MBR2 (big-endian 16-bit operand).
module ifu_prefetch #(
   parameter int DEPTH  = 8,
   parameter int ADDR_W = 32
) (
   input  logic              clk,
   input  logic              rst,
   output logic              mem_rd,
   output logic [ADDR_W-3:0] mem_addr,
   input  logic              mem_valid,
   input  logic [31:0]       mem_data,
   input  logic              consume_1,
   input  logic              consume_2,
   input  logic              pc_load,
   input  logic [ADDR_W-1:0] pc_in,
   output logic [7:0]        mbr,
   output logic [15:0]       mbr2,
   output logic              mbr_valid,
   output logic              mbr2_valid,
   output logic [ADDR_W-1:0] pc
);

   localparam int CW = $clog2(DEPTH + 1);

   logic [7:0]        buffer      [DEPTH];
   logic [7:0]        buffer_next [DEPTH];
   logic [7:0]        word_bytes  [4];
   logic [CW-1:0]     count;
   logic [CW-1:0]     count_next;
   logic [CW-1:0]     pop_n;
   logic [CW-1:0]     append_n;
   logic [CW-1:0]     remain;
   logic [ADDR_W-3:0] imar;
   logic [1:0]        skip;
   logic              pending;
   logic              drop;
   logic              accept;
   logic              issue;

   always_comb begin
      for (int k = 0; k < 4; k++) begin
         word_bytes[k] = mem_data[8*k +: 8];
      end
   end

   // A request is only issued with room for a whole word, so appends never overflow.
   always_comb begin
      pop_n = '0;
      if (consume_2 && count >= CW'(2)) begin
         pop_n = CW'(2);
      end else if (consume_1 && count >= CW'(1)) begin
         pop_n = CW'(1);
      end
      accept   = mem_valid && pending;
      append_n = '0;
      if (accept && !drop && !pc_load) begin
         append_n = CW'(4) - CW'(skip);
      end
      remain     = count - pop_n;
      count_next = pc_load ? '0 : remain + append_n;
      issue      = !pending && !pc_load && (count_next <= CW'(DEPTH - 4));
   end

   // Head sits at index 0: shift out consumed bytes, then drop new bytes in behind the survivors.
   always_comb begin
      for (int i = 0; i < DEPTH; i++) begin
         buffer_next[i] = buffer[i];
         if (pop_n == CW'(2)) begin
            buffer_next[i] = buffer[(i + 2) % DEPTH];
         end else if (pop_n == CW'(1)) begin
            buffer_next[i] = buffer[(i + 1) % DEPTH];
         end
         for (int j = 0; j < 4; j++) begin
            if (append_n > CW'(j) && remain + CW'(j) == CW'(i)) begin
               buffer_next[i] = word_bytes[skip + 2'(j)];
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      for (int i = 0; i < DEPTH; i++) begin
         buffer[i] <= buffer_next[i];
      end
   end

   // A redirect with a request in flight marks that response as stale; if it lands in the
   // redirect cycle itself it is simply discarded.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         count      <= '0;
         pc         <= '0;
         imar       <= '0;
         skip       <= '0;
         pending    <= 1'b0;
         drop       <= 1'b0;
         mem_rd     <= 1'b0;
         mem_addr   <= '0;
         mbr        <= '0;
         mbr2       <= '0;
         mbr_valid  <= 1'b0;
         mbr2_valid <= 1'b0;
      end else begin
         count      <= count_next;
         mem_rd     <= issue;
         pending    <= issue || (pending && !mem_valid);
         mbr        <= buffer_next[0];
         mbr2       <= {buffer_next[0], buffer_next[1]};
         mbr_valid  <= count_next != '0;
         mbr2_valid <= count_next >= CW'(2);
         if (issue) begin
            mem_addr <= imar;
         end
         if (pc_load) begin
            pc   <= pc_in;
            imar <= pc_in[ADDR_W-1:2];
            skip <= pc_in[1:0];
            drop <= pending && !mem_valid;
         end else begin
            pc <= pc + ADDR_W'(pop_n);
            if (issue) begin
               imar <= imar + (ADDR_W-2)'(1);
            end
            if (accept) begin
               drop <= 1'b0;
               if (!drop) begin
                  skip <= 2'b0;
               end
            end
         end
      end
   end

endmodule

// File: doc/ifu_prefetch.md
Name: ifu_prefetch

Overview:
- Instruction fetch unit for the MIC-1 datapath. It prefetches 32-bit words from the method-area memory into a byte buffer.
- It presents the next opcode/operand bytes as MBR (8-bit) and MBR2 (16-bit). The MBR output feeds the controlpath's MPC dispatch.
- The microprogram consumes bytes with single-cycle consume pulses and redirects fetch with a PC load (branches, invoke, return).

Parameters:
- DEPTH, 8, byte buffer capacity. Must be ≥ 5.
- ADDR_W, 32, width of the byte PC. The memory word address is ADDR_W-2 bits.

Ports:
- clk  input  1  clock. All state updates on posedge.
- rst  input  1  asynchronous, active-low reset.
- mem_rd  output  1  single-cycle read request pulse.
- mem_addr  output  ADDR_W-2  word address. Valid while mem_rd=1.
- mem_valid  input  1  read data valid. Exactly one pulse per request, ≥1 cycle after mem_rd.
- mem_data  input  32  read word. Byte at the lowest address is bits [7:0].
- consume_1  input  1  pop 1 byte (PC+1).
- consume_2  input  1  pop 2 bytes (PC+2).
- pc_load  input  1  redirect fetch to pc_in and flush the buffer.
- pc_in  input  ADDR_W  new byte PC.
- mbr  output  8  head byte.
- mbr2  output  16  {head byte, head+1 byte}: big-endian operand.
- mbr_valid  output  1  count ≥ 1.
- mbr2_valid  output  1  count ≥ 2.
- pc  output  ADDR_W  byte address of the head byte.

Behaviour:
- Reset (rst=0, async):
  - count=0, pc=0, imar=0, skip=0.
  - pending=0, drop=0.
  - mem_rd=0, mem_addr=0.
  - mbr=0, mbr2=0, mbr_valid=0, mbr2_valid=0.
  - Buffer contents are don't-care.
- State:
  - imar: next word address to fetch.
  - pending: one request outstanding.
  - drop: discard the next response.
  - skip[1:0]: bytes to discard from the front of the next accepted word.
- Request issue (registered): on a posedge, if pending=0, pc_load=0 and (DEPTH − count_next) ≥ 4:
  - mem_rd=1 for one cycle, mem_addr=imar.
  - Then pending=1 and imar=imar+1 (wraps modulo 2^(ADDR_W-2)).
  - First mem_rd after reset release: asserted in the cycle following the first posedge with rst=1.
- Response: on mem_valid with pending=1, set pending=0.
  - If drop=1: discard the word and clear drop.
  - Otherwise append bytes skip..3 of mem_data at the tail, then clear skip.
  - mem_valid with pending=0 is ignored.
- Consume: consume_1 pops 1 byte and sets pc+=1. consume_2 pops 2 bytes and sets pc+=2.
  - consume_1 is honoured only if count ≥ 1; consume_2 only if count ≥ 2. Otherwise it is ignored, with no state change.
  - If consume_1 and consume_2 are both high, consume_2 wins.
- Same cycle consume + response: count_next = count − n + appended. The new bytes land behind the remaining bytes; order is preserved.
- Capacity: an append can never overflow. A request is only issued with ≥4 free bytes, and consumes only free space.
- pc_load has priority over consume and response in the same cycle:
  - count=0, pc=pc_in, imar=pc_in[ADDR_W-1:2], skip=pc_in[1:0].
  - If pending=1 and mem_valid=0, set drop=1.
  - If mem_valid=1 in the same cycle, clear pending, discard the word, and do not set drop.
  - Next request is issued once pending=0.
- Outputs are registered from the buffer head, so mbr/mbr2/valids reflect the post-edge count.
- Latency, aligned redirect: for memory latency L, mbr_valid rises 1 cycle after mem_valid. That is ≥ 2+L cycles after pc_load.
- Reset mid-transfer aborts everything. A later stray mem_valid is ignored because pending=0.

Test Plan:
- Reset + cold fetch: release rst, memory L=1 returning 0x44332211 for word 0 → mem_rd at cycle 1 with mem_addr=0; mbr=0x11, mbr2=0x1122, pc=0, count=4; second mem_rd with mem_addr=1.
- Consume mix: buffer holds 11 22 33 44 55 66 77 88, consume_2 then consume_1 → mbr2=0x3344 then mbr=0x44 after the second edge; pc=3.
- Unaligned redirect: pc_load with pc_in=0x106, word 0x41 = 0xDDCCBBAA → mem_addr=0x41; buffer receives CC DD only; mbr=0xCC, pc=0x106, mbr2_valid=1.
- Redirect with request outstanding: pc_load while pending, stale word arrives, then new word → stale bytes never appear on mbr; first mbr is the byte at pc_in.
- Full buffer + underflow: DEPTH=8 with count=5 → no mem_rd issued. consume_2 with count=1 → ignored, pc unchanged.
- Simultaneous consume_1 + mem_valid with count=3 → count=6, byte order preserved, mbr = old second byte.
